// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the two buses of the fetch stage:
//   - instruction-memory port : imem_addr (to memory), imem_instr (from memory,
//                               registered, one cycle after the address)
//   - decode handshake        : if_instr / if_pc / if_valid (to decode),
//                               stall (from decode, hold request)
// Modports:
//   master : the fetch sequencer side
//   slave  : the memory/decode side (testbench, surrounding datapath)
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_instr;
    logic [15:0]         if_instr;
    logic [PC_WIDTH-1:0] if_pc;
    logic                if_valid;
    logic                stall;

    modport master (
        output imem_addr,
        input  imem_instr,
        output if_instr,
        output if_pc,
        output if_valid,
        input  stall
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  if_instr,
        input  if_pc,
        input  if_valid,
        output stall
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller for the 16-bit CPE142 datapath. Owns the PC,
// drives the registered instruction memory and hands instruction/PC pairs to
// decode with stall hold, redirect flush and a HALT state.
//
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset
//   bus (master)   : imem_addr/imem_instr memory port, if_* decode outputs,
//                    stall from decode
//   redirect_valid : taken branch/jump (highest priority, flushes)
//   redirect_pc    : redirect target, bit 0 ignored
//   resume         : leave HALT and continue from the held pc
//   halted         : high while in HALT
//   fetch_count    : delivered-instruction counter, saturating
//                    (present only when FETCH_COUNT_EN is defined)
//
// Optional feature macro: FETCH_COUNT_EN
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                  PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                resume,
    output logic                halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]         fetch_count
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc,       w_pc_nxt;
    logic                r_pend_v,   w_pend_v_nxt;
    logic [PC_WIDTH-1:0] r_pend_pc,  w_pend_pc_nxt;
    logic [15:0]         r_if_instr, w_if_instr_nxt;
    logic [PC_WIDTH-1:0] r_if_pc,    w_if_pc_nxt;
    logic                r_if_valid, w_if_valid_nxt;
    logic                w_deliver;

    // Instruction addresses are halfword aligned; clearing bit 0 by masking
    // keeps every bit of redirect_pc in use.
    logic [PC_WIDTH-1:0] w_redirect_tgt;
    assign w_redirect_tgt = redirect_pc & ~PC_WIDTH'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_v_nxt   = r_pend_v;
        w_pend_pc_nxt  = r_pend_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        w_deliver      = 1'b0;

        if (redirect_valid) begin
            // Flush wins over stall, halt and resume.
            w_state_nxt    = ST_RUN;
            w_pc_nxt       = w_redirect_tgt;
            w_pend_v_nxt   = 1'b0;
            w_if_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.stall) begin
                        // The fetch whose data arrives now is dropped, so
                        // rewind the pc to re-issue it after the stall.
                        w_pc_nxt     = r_pend_v ? r_pend_pc : r_pc;
                        w_pend_v_nxt = 1'b0;
                    end else begin
                        w_if_valid_nxt = r_pend_v;
                        if (r_pend_v) begin
                            w_deliver      = 1'b1;
                            w_if_instr_nxt = bus.imem_instr;
                            w_if_pc_nxt    = r_pend_pc;
                        end
                        if (r_pend_v && bus.imem_instr[15:12] == HALT_OPCODE) begin
                            // Halt word is delivered; the fetch issued behind
                            // it is discarded and pc parks just past it.
                            w_state_nxt  = ST_HALT;
                            w_pc_nxt     = r_pend_pc + PC_WIDTH'(2);
                            w_pend_v_nxt = 1'b0;
                        end else begin
                            w_pend_pc_nxt = r_pc;
                            w_pend_v_nxt  = 1'b1;
                            w_pc_nxt      = r_pc + PC_WIDTH'(2);
                        end
                    end
                end
                ST_HALT: begin
                    // A stalled halt instruction stays visible until decode
                    // takes it.
                    if (!bus.stall) begin
                        w_if_valid_nxt = 1'b0;
                    end
                    if (resume) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend_v   <= 1'b0;
            r_pend_pc  <= '0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_valid  = r_if_valid;
    assign halted        = (r_state == ST_HALT);

`ifdef FETCH_COUNT_EN
    logic [15:0] r_fetch_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= '0;
        end else if (w_deliver && r_fetch_count != 16'hFFFF) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    // Delivery strobe only feeds the optional counter.
    logic w_unused;
    assign w_unused = w_deliver;
`endif

endmodule
